// File: rtl/dram_link_responder_pkg.sv
// Shared types and default widths for the DRAM link responder.
package dram_link_responder_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 64;
  localparam int unsigned DEF_ADDR_WIDTH  = 16;
  localparam int unsigned DEF_WORDS_WIDTH = 16;
  localparam int unsigned DEF_TYPE_WIDTH  = 2;

  typedef enum logic [DEF_TYPE_WIDTH-1:0] {
    TT_IFMAP  = 2'd0,
    TT_FILTER = 2'd1,
    TT_BIAS   = 2'd2,
    TT_PSUM   = 2'd3
  } transfer_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_BWD  = 2'd2
  } resp_state_e;

endpackage

// File: rtl/dram_link_responder_mem.sv
// Word-addressed DRAM array: one write port, two registered read ports (link and host).
module dram_link_responder_mem
  import dram_link_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  lrd_en_i,
  input  logic [ADDR_WIDTH-1:0] lrd_addr_i,
  output logic [DATA_WIDTH-1:0] lrd_data_o,
  input  logic                  hrd_en_i,
  input  logic [ADDR_WIDTH-1:0] hrd_addr_i,
  output logic [DATA_WIDTH-1:0] hrd_data_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] lrd_data_q;
  logic [DATA_WIDTH-1:0] hrd_data_q;

  // Array contents survive reset; only the read registers clear.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Reads sample the array before this edge's write lands (read-old-data).
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      lrd_data_q <= '0;
      hrd_data_q <= '0;
    end else begin
      if (lrd_en_i) lrd_data_q <= mem_q[lrd_addr_i];
      if (hrd_en_i) hrd_data_q <= mem_q[hrd_addr_i];
    end
  end

  assign lrd_data_o = lrd_data_q;
  assign hrd_data_o = hrd_data_q;

endmodule

// File: rtl/dram_link_responder.sv
// Off-chip DRAM model: serves forward read bursts and absorbs backward write bursts
// from the accelerator link, with a host port for preload/inspection.
module dram_link_responder
  import dram_link_responder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned WORDS_WIDTH = DEF_WORDS_WIDTH,
  parameter int unsigned TYPE_WIDTH  = DEF_TYPE_WIDTH
) (
  input  logic                   link_clk,
  input  logic                   reset,
  input  logic                   start_forward,
  input  logic                   start_backward,
  input  logic [TYPE_WIDTH-1:0]  transfer_type,
  input  logic [WORDS_WIDTH-1:0] words_num,
  input  logic                   re_from_dram,
  output logic [DATA_WIDTH-1:0]  rdata_from_dram,
  output logic                   valid_from_dram,
  input  logic                   we_to_dram,
  input  logic [DATA_WIDTH-1:0]  wdata_to_dram,
  output logic                   resp_done,
  output logic                   resp_busy,
  output logic                   proto_err,
  input  logic                   host_base_we,
  input  logic [TYPE_WIDTH-1:0]  host_base_sel,
  input  logic                   host_we,
  input  logic                   host_re,
  input  logic [ADDR_WIDTH-1:0]  host_addr,
  input  logic [DATA_WIDTH-1:0]  host_wdata,
  output logic [DATA_WIDTH-1:0]  host_rdata
);

  localparam int unsigned NUM_BASE = 2 ** TYPE_WIDTH;

  resp_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
  logic [WORDS_WIDTH-1:0] rem_q, rem_d;
  logic [ADDR_WIDTH-1:0]  base_q [NUM_BASE];
  logic                   valid_q, done_q, err_q, busy_q;

  logic                   idle_c, start_c, start_fwd_c, start_bwd_c, start_zero_c;
  logic                   rd_fire_c, wr_fire_c, last_c, viol_c;
  logic                   mem_we_c;
  logic [ADDR_WIDTH-1:0]  mem_waddr_c;
  logic [DATA_WIDTH-1:0]  mem_wdata_c;

  // State register
  always_ff @(posedge link_clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: zero-length bursts never leave IDLE
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_fwd_c && !start_zero_c)      state_d = ST_FWD;
        else if (start_bwd_c && !start_zero_c) state_d = ST_BWD;
      end
      ST_FWD, ST_BWD: begin
        if (last_c) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control decode; forward wins when both starts arrive together
  always_comb begin
    idle_c       = (state_q == ST_IDLE);
    start_c      = idle_c && (start_forward || start_backward);
    start_fwd_c  = idle_c && start_forward;
    start_bwd_c  = idle_c && start_backward && !start_forward;
    start_zero_c = start_c && (words_num == '0);
    rd_fire_c    = (state_q == ST_FWD) && re_from_dram && (rem_q != '0);
    wr_fire_c    = (state_q == ST_BWD) && we_to_dram && (rem_q != '0);
    last_c       = (rd_fire_c || wr_fire_c) && (rem_q == WORDS_WIDTH'(1));
    viol_c       = (start_forward && start_backward)
                || (!idle_c && (start_forward || start_backward))
                || (re_from_dram && !rd_fire_c)
                || (we_to_dram && (state_q != ST_BWD))
                || (!idle_c && (host_we || host_re || host_base_we));
  end

  // Pointer/remaining counters; pointer wraps modulo the address space
  always_comb begin
    ptr_d = ptr_q;
    rem_d = rem_q;
    if (start_c) begin
      ptr_d = base_q[transfer_type];
      rem_d = words_num;
    end else if (rd_fire_c || wr_fire_c) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
      rem_d = rem_q - WORDS_WIDTH'(1);
    end
  end

  always_ff @(posedge link_clk) begin
    if (reset) begin
      ptr_q   <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      for (int unsigned i = 0; i < NUM_BASE; i++) base_q[i] <= '0;
    end else begin
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      valid_q <= rd_fire_c;
      done_q  <= last_c || start_zero_c;
      busy_q  <= (state_d != ST_IDLE);
      if (viol_c) err_q <= 1'b1;
      if (idle_c && host_base_we) base_q[host_base_sel] <= host_addr;
    end
  end

  // Link write has priority; host writes only reach memory while idle
  always_comb begin
    mem_we_c    = wr_fire_c || (idle_c && host_we);
    mem_waddr_c = wr_fire_c ? ptr_q : host_addr;
    mem_wdata_c = wr_fire_c ? wdata_to_dram : host_wdata;
  end

  dram_link_responder_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk_i      (link_clk),
    .reset_i    (reset),
    .we_i       (mem_we_c),
    .waddr_i    (mem_waddr_c),
    .wdata_i    (mem_wdata_c),
    .lrd_en_i   (rd_fire_c),
    .lrd_addr_i (ptr_q),
    .lrd_data_o (rdata_from_dram),
    .hrd_en_i   (idle_c && host_re),
    .hrd_addr_i (host_addr),
    .hrd_data_o (host_rdata)
  );

  assign valid_from_dram = valid_q;
  assign resp_done       = done_q;
  assign resp_busy       = busy_q;
  assign proto_err       = err_q;

endmodule
